// File: rtl/memory_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: register word, state and grant encodings.
package memory_port_arbiter_pkg;

    typedef logic [31:0] regval_t;

    localparam regval_t Nop = 32'h8000_0000;

    localparam int unsigned TimeoutWidth = 8;

    typedef enum logic [1:0] {
        Idle,
        Fetch,
        Data
    } arb_state_t;

    typedef enum logic [1:0] {
        GrantNone,
        GrantFetch,
        GrantData
    } grant_t;

    // Bits needed to hold a streak count of 0..max_streak.
    function automatic int unsigned streak_width(input int unsigned max_streak);
        return (max_streak == 0) ? 1 : $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/memory_port_arbiter_pick.sv
// Grant selection: data wins a tie unless fetch has already waited through a full data streak.
module memory_port_arbiter_pick
    import memory_port_arbiter_pkg::*;
#(
    parameter int unsigned MaxDataStreak = 4,
    parameter int unsigned StreakWidth   = 3
) (
    input  logic                   fetch_request,
    input  logic                   data_request,
    input  logic [StreakWidth-1:0] streak,
    output grant_t                 grant_c
);

    always_comb begin
        grant_c = GrantNone;
        if (fetch_request && (!data_request || streak == StreakWidth'(MaxDataStreak))) begin
            grant_c = GrantFetch;
        end else if (data_request) begin
            grant_c = GrantData;
        end
    end

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one external memory port between instruction fetch and the data path,
// with fetch starvation protection, fetch cancel and an ack timeout.
module memory_port_arbiter
    import memory_port_arbiter_pkg::*;
#(
    parameter int unsigned MaxDataStreak = 4,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        fetch_request,
    input  logic [31:0] fetch_address,
    input  logic        fetch_cancel,
    output logic [31:0] fetch_data,
    output logic        fetch_ready,
    input  logic        data_request,
    input  logic        data_is_write,
    input  logic [31:0] data_address,
    input  logic [31:0] data_write_value,
    output logic [31:0] data_read_value,
    output logic        data_ready,
    output logic        mem_request,
    output logic        mem_is_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_value,
    input  logic [31:0] mem_read_value,
    input  logic        mem_ack,
    output logic        bus_fault
);

    localparam int unsigned StreakWidth = streak_width(MaxDataStreak);

    arb_state_t              state, state_next;
    grant_t                  grant_c;
    logic [StreakWidth-1:0]  streak, streak_next;
    logic [TimeoutWidth-1:0] tcount, tcount_next;
    logic                    drop, drop_next;
    logic                    timeout_c;
    logic                    mem_request_next, mem_is_write_next;
    logic                    fetch_ready_next, data_ready_next, bus_fault_next;
    regval_t                 mem_address_next, mem_write_value_next;
    regval_t                 fetch_data_next, data_read_value_next;

    memory_port_arbiter_pick #(
        .MaxDataStreak(MaxDataStreak),
        .StreakWidth  (StreakWidth)
    ) u_pick (
        .fetch_request(fetch_request),
        .data_request (data_request),
        .streak       (streak),
        .grant_c      (grant_c)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= Idle;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            streak          <= '0;
            tcount          <= '0;
            drop            <= 1'b0;
            mem_request     <= 1'b0;
            mem_is_write    <= 1'b0;
            mem_address     <= '0;
            mem_write_value <= '0;
            fetch_data      <= Nop;
            fetch_ready     <= 1'b0;
            data_read_value <= '0;
            data_ready      <= 1'b0;
            bus_fault       <= 1'b0;
        end else begin
            streak          <= streak_next;
            tcount          <= tcount_next;
            drop            <= drop_next;
            mem_request     <= mem_request_next;
            mem_is_write    <= mem_is_write_next;
            mem_address     <= mem_address_next;
            mem_write_value <= mem_write_value_next;
            fetch_data      <= fetch_data_next;
            fetch_ready     <= fetch_ready_next;
            data_read_value <= data_read_value_next;
            data_ready      <= data_ready_next;
            bus_fault       <= bus_fault_next;
        end
    end

    // Next-state and registered-output logic; ready pulses default low every cycle.
    always_comb begin
        state_next           = state;
        streak_next          = streak;
        tcount_next          = tcount;
        drop_next            = drop;
        timeout_c            = 1'b0;
        mem_request_next     = mem_request;
        mem_is_write_next    = mem_is_write;
        mem_address_next     = mem_address;
        mem_write_value_next = mem_write_value;
        fetch_data_next      = fetch_data;
        fetch_ready_next     = 1'b0;
        data_read_value_next = data_read_value;
        data_ready_next      = 1'b0;
        bus_fault_next       = bus_fault;

        unique case (state)
            Idle: begin
                drop_next   = 1'b0;
                tcount_next = '0;
                if (!fetch_request) begin
                    streak_next = '0;
                end
                unique case (grant_c)
                    GrantFetch: begin
                        streak_next          = '0;
                        mem_request_next     = 1'b1;
                        mem_is_write_next    = 1'b0;
                        mem_address_next     = fetch_address;
                        mem_write_value_next = '0;
                        state_next           = Fetch;
                    end
                    GrantData: begin
                        if (fetch_request && streak != StreakWidth'(MaxDataStreak)) begin
                            streak_next = streak + StreakWidth'(1);
                        end
                        mem_request_next     = 1'b1;
                        mem_is_write_next    = data_is_write;
                        mem_address_next     = data_address;
                        mem_write_value_next = data_write_value;
                        state_next           = Data;
                    end
                    default: ;
                endcase
            end
            Fetch, Data: begin
                timeout_c = !mem_ack && (tcount == TimeoutWidth'(TimeoutCycles - 1));
                if (state == Fetch && fetch_cancel) begin
                    drop_next = 1'b1;
                end
                if (mem_ack || timeout_c) begin
                    mem_request_next = 1'b0;
                    tcount_next      = '0;
                    drop_next        = 1'b0;
                    state_next       = Idle;
                    if (timeout_c) begin
                        bus_fault_next = 1'b1;
                    end
                    if (state == Fetch) begin
                        // A cancelled fetch completes silently, leaving the last instruction in place.
                        if (!(drop || fetch_cancel)) begin
                            fetch_ready_next = 1'b1;
                            fetch_data_next  = mem_ack ? mem_read_value : Nop;
                        end
                    end else begin
                        data_ready_next      = 1'b1;
                        data_read_value_next = (mem_ack && !mem_is_write) ? mem_read_value : '0;
                    end
                end else begin
                    tcount_next = tcount + TimeoutWidth'(1);
                end
            end
            default: state_next = Idle;
        endcase
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter with a transaction-level reference model
// compared against the DUT every cycle.
module tb_memory_port_arbiter;

    localparam int          MaxStreak = 4;
    localparam int          Timeout   = 8;
    localparam logic [31:0] NopWord   = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        fetch_request = 1'b0;
    logic [31:0] fetch_address = '0;
    logic        fetch_cancel = 1'b0;
    logic [31:0] fetch_data;
    logic        fetch_ready;
    logic        data_request = 1'b0;
    logic        data_is_write = 1'b0;
    logic [31:0] data_address = '0;
    logic [31:0] data_write_value = '0;
    logic [31:0] data_read_value;
    logic        data_ready;
    logic        mem_request;
    logic        mem_is_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_value;
    logic [31:0] mem_read_value = '0;
    logic        mem_ack = 1'b0;
    logic        bus_fault;

    memory_port_arbiter #(
        .MaxDataStreak(MaxStreak),
        .TimeoutCycles(Timeout)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .fetch_request   (fetch_request),
        .fetch_address   (fetch_address),
        .fetch_cancel    (fetch_cancel),
        .fetch_data      (fetch_data),
        .fetch_ready     (fetch_ready),
        .data_request    (data_request),
        .data_is_write   (data_is_write),
        .data_address    (data_address),
        .data_write_value(data_write_value),
        .data_read_value (data_read_value),
        .data_ready      (data_ready),
        .mem_request     (mem_request),
        .mem_is_write    (mem_is_write),
        .mem_address     (mem_address),
        .mem_write_value (mem_write_value),
        .mem_read_value  (mem_read_value),
        .mem_ack         (mem_ack),
        .bus_fault       (bus_fault)
    );

    always #5 clock = ~clock;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
        end
    endtask

    task automatic wait_ready(input bit fetch_side, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            seen = fetch_side ? fetch_ready : data_ready;
        end
        if (!seen) begin
            tests_run++;
            tests_failed++;
            $display("FAIL wait_ready: no %s ready within %0d cycles", fetch_side ? "fetch" : "data", budget);
        end
    endtask

    // Memory responder: acks ack_delay cycles after mem_request rises (-1 = never).
    int          ack_delay = -1;
    logic [31:0] rd_value = '0;
    int          mem_age = 0;
    always @(negedge clock) begin
        if (mem_request) mem_age++;
        else             mem_age = 0;
        mem_ack        = mem_request && (ack_delay >= 0) && (mem_age == ack_delay + 1);
        mem_read_value = rd_value;
    end

    // Reference model: owner 0 = none, 1 = fetch, 2 = data.
    int          owner = 0;
    int          waited = 0;
    int          m_streak = 0;
    bit          m_drop = 1'b0;
    bit          m_write = 1'b0;
    bit          timed_out = 1'b0;
    logic        e_mem_request = 1'b0;
    logic        e_mem_is_write = 1'b0;
    logic [31:0] e_mem_address = '0;
    logic [31:0] e_mem_write_value = '0;
    logic [31:0] e_fetch_data = NopWord;
    logic        e_fetch_ready = 1'b0;
    logic [31:0] e_data_read_value = '0;
    logic        e_data_ready = 1'b0;
    logic        e_bus_fault = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner = 0; waited = 0; m_streak = 0; m_drop = 1'b0; m_write = 1'b0;
            e_mem_request = 1'b0; e_fetch_ready = 1'b0; e_data_ready = 1'b0;
            e_fetch_data = NopWord; e_data_read_value = '0; e_bus_fault = 1'b0;
        end else begin
            e_fetch_ready = 1'b0;
            e_data_ready  = 1'b0;
            if (owner == 0) begin
                m_drop = 1'b0;
                waited = 0;
                if (!fetch_request) m_streak = 0;
                if (fetch_request && (!data_request || m_streak == MaxStreak)) begin
                    owner = 1; m_streak = 0; m_write = 1'b0;
                    e_mem_request = 1'b1; e_mem_is_write = 1'b0; e_mem_address = fetch_address;
                end else if (data_request) begin
                    owner = 2; m_write = data_is_write;
                    if (fetch_request && m_streak < MaxStreak) m_streak++;
                    e_mem_request = 1'b1; e_mem_is_write = data_is_write;
                    e_mem_address = data_address; e_mem_write_value = data_write_value;
                end
            end else begin
                if (owner == 1 && fetch_cancel) m_drop = 1'b1;
                timed_out = !mem_ack && (waited + 1 == Timeout);
                if (mem_ack || timed_out) begin
                    if (owner == 1) begin
                        if (!m_drop) begin
                            e_fetch_ready = 1'b1;
                            e_fetch_data  = mem_ack ? mem_read_value : NopWord;
                        end
                    end else begin
                        e_data_ready      = 1'b1;
                        e_data_read_value = (mem_ack && !m_write) ? mem_read_value : 32'h0;
                    end
                    if (timed_out) e_bus_fault = 1'b1;
                    owner = 0;
                    e_mem_request = 1'b0;
                end else begin
                    waited++;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        check("mem_request", 32'(mem_request), 32'(e_mem_request));
        check("fetch_ready", 32'(fetch_ready), 32'(e_fetch_ready));
        check("fetch_data", fetch_data, e_fetch_data);
        check("data_ready", 32'(data_ready), 32'(e_data_ready));
        check("data_read_value", data_read_value, e_data_read_value);
        check("bus_fault", 32'(bus_fault), 32'(e_bus_fault));
        if (e_mem_request) begin
            check("mem_address", mem_address, e_mem_address);
            check("mem_is_write", 32'(mem_is_write), 32'(e_mem_is_write));
            if (owner == 2) check("mem_write_value", mem_write_value, e_mem_write_value);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    string seq;
    int    grants;
    int    cnt;
    logic  prev;

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        check("reset fetch_data", fetch_data, NopWord);
        check("reset mem_request", 32'(mem_request), 32'h0);
        check("reset data_read_value", data_read_value, 32'h0);
        check("reset bus_fault", 32'(bus_fault), 32'h0);
        #2 reset_n = 1'b1;
        @(negedge clock);

        // Lone fetch, ack one cycle after mem_request.
        fetch_address = 32'h100; fetch_request = 1'b1; ack_delay = 1; rd_value = 32'h1234_5678;
        @(negedge clock);
        check("t1 mem_request c1", 32'(mem_request), 32'h1);
        check("t1 mem_address", mem_address, 32'h100);
        @(negedge clock);
        check("t1 no ready c2", 32'(fetch_ready), 32'h0);
        @(negedge clock);
        check("t1 fetch_ready c3", 32'(fetch_ready), 32'h1);
        check("t1 fetch_data", fetch_data, 32'h1234_5678);
        fetch_request = 1'b0;
        @(negedge clock);
        check("t1 ready one cycle", 32'(fetch_ready), 32'h0);

        // Simultaneous fetch and load: data first, fetch right after data_ready.
        fetch_address = 32'h104; fetch_request = 1'b1;
        data_address = 32'h200; data_is_write = 1'b0; data_write_value = '0; data_request = 1'b1;
        ack_delay = 0; rd_value = 32'hA5A5_0001;
        @(negedge clock);
        check("t2 data granted", mem_address, 32'h200);
        check("t2 load flag", 32'(mem_is_write), 32'h0);
        @(negedge clock);
        check("t2 data_ready", 32'(data_ready), 32'h1);
        check("t2 data_read_value", data_read_value, 32'hA5A5_0001);
        data_request = 1'b0; rd_value = 32'h0000_0013;
        @(negedge clock);
        check("t2 fetch granted", 32'(mem_request), 32'h1);
        check("t2 fetch address", mem_address, 32'h104);
        @(negedge clock);
        check("t2 fetch_data", fetch_data, 32'h0000_0013);
        fetch_request = 1'b0;
        @(negedge clock);

        // Both requesting continuously: four data grants, then fetch, then streak restarts.
        fetch_address = 32'h108; data_address = 32'h204; rd_value = 32'h0000_0AAA; ack_delay = 0;
        fetch_request = 1'b1; data_request = 1'b1;
        seq = ""; grants = 0; prev = 1'b0;
        for (int i = 0; i < 200 && grants < 10; i++) begin
            @(negedge clock);
            if (mem_request && !prev) begin
                seq = {seq, (mem_address == 32'h108) ? "F" : "D"};
                grants++;
            end
            prev = mem_request;
        end
        check_str("t3 grant order", seq, "DDDDFDDDDF");
        wait_ready(1'b1, 10);
        fetch_request = 1'b0; data_request = 1'b0;
        @(negedge clock);
        check("t3 last fetch_data", fetch_data, 32'h0000_0AAA);

        // Cancel one cycle after mem_request; ack arrives three cycles later.
        fetch_address = 32'h10C; fetch_request = 1'b1; ack_delay = 4; rd_value = 32'hBAD0_BAD0;
        @(negedge clock);
        check("t4 mem_request", 32'(mem_request), 32'h1);
        @(negedge clock);
        fetch_cancel = 1'b1; fetch_request = 1'b0;
        @(negedge clock);
        fetch_cancel = 1'b0;
        check("t4 no fetch_ready", 32'(fetch_ready), 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("t4 no fetch_ready", 32'(fetch_ready), 32'h0);
        end
        check("t4 fetch_data kept", fetch_data, 32'h0000_0AAA);
        check("t4 transaction ended", 32'(mem_request), 32'h0);
        fetch_address = 32'h110; fetch_request = 1'b1; ack_delay = 1; rd_value = 32'h1111_1111;
        wait_ready(1'b1, 10);
        check("t4 next fetch_data", fetch_data, 32'h1111_1111);
        fetch_request = 1'b0;
        @(negedge clock);

        // Ack on the last cycle before the limit wins over the timeout.
        data_address = 32'h208; data_is_write = 1'b0; data_request = 1'b1;
        ack_delay = 7; rd_value = 32'h5555_AAAA;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (mem_request) cnt++;
            else if (cnt > 0) break;
        end
        check("t5a cycles in Data", 32'(cnt), 32'd8);
        check("t5a data_ready", 32'(data_ready), 32'h1);
        check("t5a data_read_value", data_read_value, 32'h5555_AAAA);
        check("t5a no fault", 32'(bus_fault), 32'h0);
        data_request = 1'b0;
        @(negedge clock);

        // Store that is never acked times out after eight cycles.
        data_address = 32'h300; data_is_write = 1'b1; data_write_value = 32'hDEAD_BEEF;
        data_request = 1'b1; ack_delay = -1;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (mem_request) begin
                if (cnt == 0) begin
                    check("t5b store flag", 32'(mem_is_write), 32'h1);
                    check("t5b store value", mem_write_value, 32'hDEAD_BEEF);
                end
                cnt++;
            end else if (cnt > 0) begin
                break;
            end
        end
        check("t5b cycles in Data", 32'(cnt), 32'd8);
        check("t5b data_ready", 32'(data_ready), 32'h1);
        check("t5b data_read_value", data_read_value, 32'h0);
        check("t5b bus_fault", 32'(bus_fault), 32'h1);
        data_request = 1'b0; data_is_write = 1'b0;
        repeat (3) @(negedge clock);
        check("t5b bus_fault sticky", 32'(bus_fault), 32'h1);

        // Reset in the middle of a data transaction.
        data_address = 32'h20C; data_request = 1'b1; ack_delay = -1;
        repeat (2) @(negedge clock);
        check("t6 in Data", 32'(mem_request), 32'h1);
        #2 reset_n = 1'b0; data_request = 1'b0;
        #1;
        check("t6 reset mem_request", 32'(mem_request), 32'h0);
        check("t6 reset bus_fault", 32'(bus_fault), 32'h0);
        check("t6 reset fetch_data", fetch_data, NopWord);
        check("t6 reset data_ready", 32'(data_ready), 32'h0);
        @(negedge clock);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("t6 no data_ready", 32'(data_ready), 32'h0);
            check("t6 idle", 32'(mem_request), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
- Shares the core's single external memory port between two requesters: instruction fetch (read-only) and the data path (load/store from the read/write stages).
- Grants one transaction at a time and forwards it to memory with a request/ack handshake.
- Returns each result to its owner with a one-cycle ready pulse; the pipeline turns the absence of ready into hold.
- Handles fetch cancellation on PC change, starvation protection for fetch, and a memory-ack timeout with a sticky fault flag.

Parameters:
- MaxDataStreak, 4: consecutive data grants allowed while fetch is waiting; afterwards fetch gets the next grant.
- TimeoutCycles, 255: cycles in Fetch/Data state without mem_ack before the transaction is aborted; valid range 1..255.

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- fetch_request  in  1  fetch wants the word at fetch_address
- fetch_address  in  32  byte address, held stable until fetch_ready or cancel
- fetch_cancel  in  1  is_pc_changing from decode; discards the outstanding fetch result
- fetch_data  out  32  instruction word, valid while fetch_ready=1
- fetch_ready  out  1  one-cycle completion pulse
- data_request  in  1  data access wanted
- data_is_write  in  1  1 = store, 0 = load
- data_address  in  32  byte address
- data_write_value  in  32  store data
- data_read_value  out  32  load result, valid while data_ready=1
- data_ready  out  1  one-cycle completion pulse
- mem_request  out  1  transaction active toward memory
- mem_is_write  out  1  store flag
- mem_address  out  32  address
- mem_write_value  out  32  store data
- mem_read_value  in  32  memory read data, sampled on mem_ack
- mem_ack  in  1  memory completion; may arrive 1..N cycles after mem_request rises
- bus_fault  out  1  sticky flag, set on timeout

Behaviour:
- Reset (async, reset_n=0):
  - state=Idle; streak counter and timeout counter cleared.
  - All mem_* outputs, ready pulses, data_read_value and bus_fault are 0.
  - fetch_data = Nop (32'h80000000).
- States:
  - Idle: choose a grant. No request → stay. Only one request → grant it. Both → data wins, unless streak == MaxDataStreak, in which case fetch wins.
  - The granted request's address and data are registered onto mem_*, mem_request=1, and the state moves to Fetch or Data at the next edge.
  - Grant latency: 1 cycle from request to mem_request.
- Fetch/Data states:
  - mem_* stay stable while mem_request=1.
  - On a cycle with mem_ack=1: at the next edge, mem_request=0, the result is latched into fetch_data or data_read_value, the owner's ready pulses for exactly one cycle, and state returns to Idle.
  - Minimum request-to-ready time: 2 cycles.
- Requester contract:
  - Keep the request high and its inputs stable until ready.
  - A request seen in the ready cycle is a new transaction and may be granted at that edge.
- Streak counter:
  - Increments on each data grant made while fetch_request=1; saturates at MaxDataStreak.
  - Clears on a fetch grant, or whenever fetch_request=0 in Idle.
- Cancel:
  - fetch_cancel=1 in any cycle of the Fetch state (including the ack cycle) sets a drop flag.
  - The memory transaction still runs to ack, but fetch_ready is suppressed and fetch_data is left unchanged.
  - The drop flag clears on return to Idle.
  - Cancel in Idle or Data state has no effect.
- Timeout:
  - The counter starts at 0 on entry to Fetch/Data and increments each cycle mem_ack=0.
  - When it reaches TimeoutCycles: mem_request drops, the owner's ready pulses with fetch_data=Nop or data_read_value=0, bus_fault is set, state returns to Idle.
  - bus_fault clears only on reset.
  - If mem_ack arrives in the same cycle the limit is reached, the ack wins and there is no fault.
- Stores: data_read_value on a store completion is 0.
- Reset mid-transaction: immediate Idle, mem_request=0, no ready pulse after release.

Decomposition:
- Shared package:
  - regval_t and Nop, already shared with the core.
  - Enum arb_state_t {Idle, Fetch, Data}.
  - Enum grant_t {GrantNone, GrantFetch, GrantData}.
- One combinational sub-module, memory_port_arbiter_pick:
  - Inputs: the two requests, the streak count, MaxDataStreak.
  - Output: grant_t.
  - Lets the priority rule be unit-tested in isolation.

Test Plan:
- Lone fetch, fetch_address=0x100, memory acks 1 cycle after mem_request with 0x12345678 → mem_request in cycle 1, fetch_ready in cycle 3, fetch_data=0x12345678.
- Simultaneous fetch and load, data_address=0x200 → data granted first (mem_is_write=0, mem_address=0x200); fetch granted in the Idle cycle after data_ready.
- Continuous data requests with fetch held high, MaxDataStreak=4 → exactly 4 data grants, then a fetch grant, then the streak resets.
- fetch_cancel pulsed 1 cycle after mem_request, ack 3 cycles later → no fetch_ready, fetch_data unchanged, next grant proceeds normally.
- Store to 0x300 value 0xDEADBEEF, memory never acks, TimeoutCycles=8 → mem_request drops after 8 cycles in Data, data_ready pulses with value 0, bus_fault=1 held until reset_n=0.
- reset_n asserted while in Data with mem_request=1 → outputs go to reset values immediately; after release, no ready pulse and state is Idle.
